sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Writer counterpart to the palette-indexed sprite readers: copies one SPR_W x SPR_H sprite of 4-bit palette indices from a sprite ROM into the 640x480 index framebuffer at a requested top-left position.
- Sits between game logic (issues start with position) and the framebuffer write port. The scan-out side later reads that framebuffer through the palette.
- Skips transparent pixels and clips anything that falls off-screen.

Parameters:
- SPR_W, 24, sprite width in pixels
- SPR_H, 24, sprite height in pixels
- SCREEN_W, 640, framebuffer width
- SCREEN_H, 480, framebuffer height
- IDX_W, 4, palette index width
- TRANSP_IDX, 0, index treated as transparent (never written)
- FB_AW, 19, framebuffer address width

Ports:
- vga_clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request blit; sampled only in IDLE
- pos_x  in  10  sprite left column, latched on accepted start
- pos_y  in  10  sprite top row, latched on accepted start
- busy  out  1  high from the cycle after accepted start through the DONE cycle
- done  out  1  one-cycle pulse when the blit completes
- rom_addr  out  10  sprite ROM address = row*SPR_W + col
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr is presented (synchronous ROM)
- fb_we  out  1  framebuffer write request
- fb_addr  out  FB_AW  (pos_y+row)*SCREEN_W + (pos_x+col)
- fb_data  out  IDX_W  index to write
- fb_ready  in  1  write accepted on an edge where fb_we && fb_ready

Behaviour:
- Reset (asynchronous, immediate): state IDLE; busy, done, fb_we = 0; rom_addr, fb_addr, fb_data, row, col = 0. Reset mid-blit abandons the blit with no further writes and no done pulse.
- States:
  - IDLE: start=1 latches pos_x/pos_y, clears row/col, and moves to FETCH.
  - FETCH: drive rom_addr for (row,col); always moves to WRITE next cycle.
  - WRITE: rom_q is valid. rom_addr is held so rom_q stays valid during a stall.
    - If rom_q==TRANSP_IDX, or pos_x+col >= SCREEN_W, or pos_y+row >= SCREEN_H: fb_we=0, advance immediately.
    - Otherwise fb_we=1, fb_addr/fb_data driven combinationally from current state. Hold them unchanged until fb_ready=1, then advance.
  - Advance: col++. When col wraps at SPR_W, col=0 and row++. After the last pixel (row=SPR_H-1, col=SPR_W-1), go to DONE; otherwise go to FETCH.
  - DONE: done=1, busy=1 for exactly one cycle, then IDLE.
- Throughput: 2 cycles per pixel with fb_ready=1.
- Latency: start sampled at edge k -> done high in cycle k+1+2*SPR_W*SPR_H, which is 1153 cycles for 24x24.
- Arithmetic: clip compares use 11-bit sums (no wrap). fb_addr is computed only for in-bounds pixels; its maximum is 307199, which fits in 19 bits.
- start while busy is ignored; it is not queued. start in the same cycle done is high is also ignored. pos_x/pos_y changes during a blit have no effect.

Decomposition:
- Package sprite_pkg holds:
  - SCREEN_W, SCREEN_H, SPR_W, SPR_H, IDX_W, FB_AW, TRANSP_IDX
  - enum blit_state_t {IDLE, FETCH, WRITE, DONE}
- One sub-module: blit_addr_gen. It is purely combinational: from latched pos, row and col it produces rom_addr, fb_addr and the in_bounds flag.

Test Plan:
- Opaque sprite (all index 5), pos (0,0), fb_ready=1:
  - exactly 576 writes
  - first write fb_addr=0, last fb_addr=14743, all fb_data=5
  - done pulses once, 1153 cycles after start
- Clipping, opaque sprite at (630,470): exactly 100 writes (cols 0-9, rows 0-9); last fb_addr=479*640+639=307199; no address >= 307200.
- Checkerboard sprite (index 0 on (row+col) even, 9 otherwise): exactly 288 writes, none with fb_data=0; done timing unchanged (1153).
- Stall: fb_ready=0 for 5 cycles at the first write:
  - fb_we, fb_addr and fb_data stay constant throughout the stall
  - rom_addr is held
  - done arrives 5 cycles later (1158)
- Start while busy: pulse start with pos (100,100) mid-blit of (0,0). No write outside the 24x24 region at origin and a single done pulse. A new start after done is accepted.
- Reset mid-blit: assert reset_n=0 at pixel 200. fb_we/busy drop the same cycle without waiting for a clock edge. No done pulse. A subsequent start produces a full correct blit.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg
// Shared geometry, widths and FSM state encoding for the sprite blitter.
// Holds no ports. It is imported by blit_addr_gen and sprite_blitter.
package sprite_pkg;

    localparam int SPR_W    = 24;
    localparam int SPR_H    = 24;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int IDX_W    = 4;
    localparam int FB_AW    = 19;

    localparam logic [IDX_W-1:0] TRANSP_IDX = '0;

    localparam int POS_W  = 10;
    localparam int SUM_W  = POS_W + 1;   // screen coordinate sums never wrap
    localparam int ROM_AW = 10;
    localparam int ROW_W  = $clog2(SPR_H);
    localparam int COL_W  = $clog2(SPR_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen
// Purely combinational address generation for the sprite blitter.
// It maps the sprite-relative (row, col) to a sprite ROM address and a framebuffer address.
// It also flags whether the target pixel lies on screen.
//   pos_x, pos_y : latched sprite top-left position
//   row, col     : current sprite pixel
//   rom_addr     : row*SPR_W + col
//   fb_addr      : (pos_y+row)*SCREEN_W + (pos_x+col); only meaningful when in_bounds
//   in_bounds    : target pixel is inside the SCREEN_W x SCREEN_H framebuffer
module blit_addr_gen
    import sprite_pkg::*;
(
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    input  logic [ROW_W-1:0]  row,
    input  logic [COL_W-1:0]  col,
    output logic [ROM_AW-1:0] rom_addr,
    output logic [FB_AW-1:0]  fb_addr,
    output logic              in_bounds
);

    logic [SUM_W-1:0] scr_x;
    logic [SUM_W-1:0] scr_y;

    always_comb begin
        scr_x     = {1'b0, pos_x} + SUM_W'(col);
        scr_y     = {1'b0, pos_y} + SUM_W'(row);
        in_bounds = (scr_x < SUM_W'(SCREEN_W)) && (scr_y < SUM_W'(SCREEN_H));
        rom_addr  = ROM_AW'(row) * ROM_AW'(SPR_W) + ROM_AW'(col);
        // Truncation only affects off-screen pixels, which are never written.
        fb_addr   = FB_AW'(scr_y) * FB_AW'(SCREEN_W) + FB_AW'(scr_x);
    end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter
// Copies one SPR_W x SPR_H sprite of palette indices from a synchronous sprite ROM
// into the index framebuffer at (pos_x, pos_y).
// Transparent pixels are skipped and off-screen pixels are clipped.
//   vga_clk, reset_n    : clock, async active-low reset
//   start, pos_x, pos_y : blit request and top-left position (sampled in IDLE)
//   busy, done          : blit in progress / one-cycle completion pulse
//   rom_addr, rom_q     : sprite ROM port (data one cycle after address)
//   fb_we, fb_addr, fb_data, fb_ready : framebuffer write port with back-pressure
//
// state | meaning
// IDLE  | waiting for start
// FETCH | rom_addr presented for (row, col)
// WRITE | rom_q valid; write pixel (hold until fb_ready) or skip
// DONE  | one-cycle completion pulse
module sprite_blitter
    import sprite_pkg::*;
(
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [POS_W-1:0]  pos_x,
    input  logic [POS_W-1:0]  pos_y,
    output logic              busy,
    output logic              done,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [IDX_W-1:0]  rom_q,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [IDX_W-1:0]  fb_data,
    input  logic              fb_ready
);

    blit_state_t      state;
    logic [POS_W-1:0] pos_x_q;
    logic [POS_W-1:0] pos_y_q;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    logic [FB_AW-1:0] fb_addr_raw;
    logic             in_bounds;
    logic             pix_write;
    logic             advance;
    logic             last_pix;

    // row/col do not move during WRITE, so rom_addr (and therefore rom_q) stays put through a stall.
    blit_addr_gen u_addr_gen (
        .pos_x     (pos_x_q),
        .pos_y     (pos_y_q),
        .row       (row),
        .col       (col),
        .rom_addr  (rom_addr),
        .fb_addr   (fb_addr_raw),
        .in_bounds (in_bounds)
    );

    always_comb begin
        pix_write = (state == WRITE) && (rom_q != TRANSP_IDX) && in_bounds;
        advance   = (state == WRITE) && (!pix_write || fb_ready);
        last_pix  = (row == ROW_W'(SPR_H - 1)) && (col == COL_W'(SPR_W - 1));
    end

    // Write-port outputs are gated by state, so a reset drops them immediately.
    assign fb_we   = pix_write;
    assign fb_addr = pix_write ? fb_addr_raw : '0;
    assign fb_data = pix_write ? rom_q : '0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            pos_x_q <= '0;
            pos_y_q <= '0;
            row     <= '0;
            col     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pos_x_q <= pos_x;
                        pos_y_q <= pos_y;
                        row     <= '0;
                        col     <= '0;
                        state   <= FETCH;
                    end
                end
                FETCH: state <= WRITE;
                WRITE: begin
                    if (advance) begin
                        if (last_pix) begin
                            state <= DONE;
                        end else begin
                            state <= FETCH;
                            if (col == COL_W'(SPR_W - 1)) begin
                                col <= '0;
                                row <= row + ROW_W'(1);
                            end else begin
                                col <= col + COL_W'(1);
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;
    import sprite_pkg::*;

    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  pos_x;
    logic [9:0]  pos_y;
    logic        busy;
    logic        done;
    logic [9:0]  rom_addr;
    logic [3:0]  rom_q = '0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [3:0]  fb_data;
    logic        fb_ready;

    always #5 vga_clk = ~vga_clk;

    sprite_blitter dut (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_data  (fb_data),
        .fb_ready (fb_ready)
    );

    // Synchronous sprite ROM model
    logic [3:0] mem [0:1023];
    always @(posedge vga_clk) rom_q <= mem[rom_addr];

    int cyc = 0;
    always @(posedge vga_clk) cyc <= cyc + 1;

    // Write monitor: checks every accepted write against the expected sprite region and pattern
    int          writes, done_cnt, bad_writes;
    int          exp_px, exp_py, pattern;
    logic [18:0] first_addr, last_addr;
    int          mx, my;

    always @(negedge vga_clk) begin
        if (done) done_cnt++;
        if (fb_we && fb_ready) begin
            mx = int'(fb_addr) % 640;
            my = int'(fb_addr) / 640;
            if (writes == 0) first_addr = fb_addr;
            last_addr = fb_addr;
            writes++;
            if (int'(fb_addr) >= 307200 || mx < exp_px || mx >= exp_px + 24 ||
                my < exp_py || my >= exp_py + 24)
                bad_writes++;
            else if (pattern == 0 && fb_data != 4'd5)
                bad_writes++;
            else if (pattern == 1 &&
                     ((((mx - exp_px) + (my - exp_py)) % 2 == 0) || fb_data != 4'd9))
                bad_writes++;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int start_cyc;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pattern(input int pat);
        for (int i = 0; i < 1024; i++) mem[i] = 4'd0;
        for (int r = 0; r < 24; r++)
            for (int c = 0; c < 24; c++)
                mem[r*24 + c] = (pat == 0) ? 4'd5 : (((r + c) % 2 == 0) ? 4'd0 : 4'd9);
    endtask

    task automatic clear_mon(input int px, input int py, input int pat);
        exp_px = px; exp_py = py; pattern = pat;
        writes = 0; done_cnt = 0; bad_writes = 0;
        first_addr = '0; last_addr = '0;
    endtask

    task automatic start_blit(input int px, input int py);
        @(negedge vga_clk);
        pos_x = 10'(px);
        pos_y = 10'(py);
        start = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
        start_cyc = cyc;
        // Position changes mid-blit must be ignored
        pos_x = ~pos_x;
        pos_y = ~pos_y;
    endtask

    // Latency counts the start-sampling cycle as cycle 1; -1 means timeout
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge vga_clk);
            if (done) begin
                lat = cyc - start_cyc + 1;
                break;
            end
        end
    endtask

    typedef struct {
        int px, py, pat;
        int exp_writes, exp_first, exp_last, exp_lat;
    } vec_t;

    vec_t vecs [6];

    int          lat, snap;
    logic        s_we, pre_we, pre_busy;
    logic [18:0] s_addr;
    logic [3:0]  s_data;
    logic [9:0]  s_rom;

    initial begin
        //          px   py   pat writes first   last    lat
        vecs[0] = '{0,   0,   0,  576,   0,      14743,  1153};
        vecs[1] = '{630, 470, 0,  100,   301430, 307199, 1153};
        vecs[2] = '{0,   0,   1,  288,   1,      14742,  1153};
        vecs[3] = '{639, 479, 0,  1,     307199, 307199, 1153};
        vecs[4] = '{100, 50,  1,  288,   32101,  46842,  1153};
        vecs[5] = '{620, 460, 1,  200,   295021, 307198, 1153};

        reset_n = 1'b0; start = 1'b0; pos_x = '0; pos_y = '0; fb_ready = 1'b1;
        set_pattern(0);
        clear_mon(0, 0, 0);
        #3;
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_fb_we", int'(fb_we), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_fb_addr", int'(fb_addr), 0);
        check("reset_fb_data", int'(fb_data), 0);
        repeat (3) @(negedge vga_clk);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            set_pattern(vecs[v].pat);
            clear_mon(vecs[v].px, vecs[v].py, vecs[v].pat);
            start_blit(vecs[v].px, vecs[v].py);
            check($sformatf("v%0d_busy_after_start", v), int'(busy), 1);
            wait_done(lat);
            repeat (3) @(negedge vga_clk);
            check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
            check($sformatf("v%0d_writes", v), writes, vecs[v].exp_writes);
            check($sformatf("v%0d_first_addr", v), int'(first_addr), vecs[v].exp_first);
            check($sformatf("v%0d_last_addr", v), int'(last_addr), vecs[v].exp_last);
            check($sformatf("v%0d_done_pulses", v), done_cnt, 1);
            check($sformatf("v%0d_bad_writes", v), bad_writes, 0);
            check($sformatf("v%0d_busy_idle", v), int'(busy), 0);
        end

        // Stall: first write held off for 5 cycles
        set_pattern(0);
        clear_mon(0, 0, 0);
        fb_ready = 1'b0;
        start_blit(0, 0);
        for (int i = 0; i < 10; i++) begin
            if (fb_we) break;
            @(negedge vga_clk);
        end
        check("stall_we_seen", int'(fb_we), 1);
        s_we = fb_we; s_addr = fb_addr; s_data = fb_data; s_rom = rom_addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge vga_clk);
            check($sformatf("stall%0d_fb_we", i), int'(fb_we), int'(s_we));
            check($sformatf("stall%0d_fb_addr", i), int'(fb_addr), int'(s_addr));
            check($sformatf("stall%0d_fb_data", i), int'(fb_data), int'(s_data));
            check($sformatf("stall%0d_rom_addr", i), int'(rom_addr), int'(s_rom));
        end
        fb_ready = 1'b1;
        wait_done(lat);
        repeat (3) @(negedge vga_clk);
        check("stall_latency", lat, 1158);
        check("stall_writes", writes, 576);
        check("stall_done_pulses", done_cnt, 1);
        check("stall_bad_writes", bad_writes, 0);

        // Start while busy, and start coincident with done, are both ignored
        clear_mon(0, 0, 0);
        start_blit(0, 0);
        repeat (300) @(negedge vga_clk);
        pos_x = 10'd100; pos_y = 10'd100; start = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
        wait_done(lat);
        start = 1'b1;
        @(negedge vga_clk);
        start = 1'b0;
        check("start_on_done_ignored", int'(busy), 0);
        repeat (3) @(negedge vga_clk);
        check("busy_start_latency", lat, 1153);
        check("busy_start_writes", writes, 576);
        check("busy_start_done_pulses", done_cnt, 1);
        check("busy_start_bad_writes", bad_writes, 0);

        clear_mon(100, 100, 0);
        start_blit(100, 100);
        wait_done(lat);
        repeat (3) @(negedge vga_clk);
        check("restart_writes", writes, 576);
        check("restart_first_addr", int'(first_addr), 64100);
        check("restart_last_addr", int'(last_addr), 78843);
        check("restart_done_pulses", done_cnt, 1);
        check("restart_bad_writes", bad_writes, 0);

        // Reset mid-blit at pixel 200
        clear_mon(0, 0, 0);
        start_blit(0, 0);
        for (int i = 0; i < 2000; i++) begin
            @(negedge vga_clk);
            #1;
            if (writes >= 200) break;
        end
        check("mid_writes_reached", writes, 200);
        pre_we = fb_we; pre_busy = busy;
        check("pre_reset_fb_we", int'(pre_we), 1);
        check("pre_reset_busy", int'(pre_busy), 1);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_fb_we", int'(fb_we), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_fb_addr", int'(fb_addr), 0);
        snap = writes;
        repeat (2) @(negedge vga_clk);
        reset_n = 1'b1;
        repeat (1300) @(negedge vga_clk);
        check("reset_no_done", done_cnt, 0);
        check("reset_no_more_writes", writes, snap);

        clear_mon(0, 0, 0);
        start_blit(0, 0);
        wait_done(lat);
        repeat (3) @(negedge vga_clk);
        check("post_reset_latency", lat, 1153);
        check("post_reset_writes", writes, 576);
        check("post_reset_last_addr", int'(last_addr), 14743);
        check("post_reset_done_pulses", done_cnt, 1);
        check("post_reset_bad_writes", bad_writes, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
